// File: rtl/dm_bus_arb.sv
// dm_bus_arb: shares one data-bus slave port between the core LSU (master 0)
// and the debug module system-bus path (master 1). One transaction in flight,
// debug priority bounded by a fairness cap, response timeout on the slave.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no transaction; arbitrate between core_req and dbg_req
// ISSUE  | s_req asserted with the owner's latched fields, waiting for s_gnt
// WAIT   | handshake done, waiting for s_rvalid or the response timeout
module dm_bus_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DBG_MAX = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_done,
    output logic              core_err,
    output logic              core_hold,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    output logic              dbg_err,
    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_gnt,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int CNT_W = $clog2(DBG_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DBG_MAX);

    // The timeout is a down-counter loaded on the handshake. Because the
    // completion flops add one cycle, the terminal count is reached one cycle
    // before the done pulse, so the load value is TIMEOUT-2. TIMEOUT of 1 or 2
    // both collapse to the shortest legal response window.
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = (TIMEOUT > 2) ? TMO_W'(TIMEOUT - 2) : '0;

    state_e             state_q,      state_d;
    logic               owner_dbg_q,  owner_dbg_d;
    logic [CNT_W-1:0]   dbg_cnt_q,    dbg_cnt_d;
    logic [TMO_W-1:0]   tmo_q,        tmo_d;
    logic               s_req_q,      s_req_d;
    logic               s_we_q,       s_we_d;
    logic [ADDR_W-1:0]  s_addr_q,     s_addr_d;
    logic [DATA_W-1:0]  s_wdata_q,    s_wdata_d;
    logic               core_done_q,  core_done_d;
    logic               core_err_q,   core_err_d;
    logic [DATA_W-1:0]  core_rdata_q, core_rdata_d;
    logic               dbg_done_q,   dbg_done_d;
    logic               dbg_err_q,    dbg_err_d;
    logic [DATA_W-1:0]  dbg_rdata_q,  dbg_rdata_d;

    logic               dbg_win;
    logic               fin;
    logic               fin_err;
    logic [DATA_W-1:0]  fin_rdata;

    // Debug wins unless the core is waiting and debug has used up its streak.
    assign dbg_win = dbg_req & (~core_req | (dbg_cnt_q < CNT_MAX));

    // Next-state, slave-side and completion logic.
    always_comb begin
        state_d      = state_q;
        owner_dbg_d  = owner_dbg_q;
        dbg_cnt_d    = dbg_cnt_q;
        tmo_d        = tmo_q;
        s_req_d      = s_req_q;
        s_we_d       = s_we_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        core_done_d  = 1'b0;
        core_err_d   = 1'b0;
        core_rdata_d = '0;
        dbg_done_d   = 1'b0;
        dbg_err_d    = 1'b0;
        dbg_rdata_d  = '0;
        fin          = 1'b0;
        fin_err      = 1'b0;
        fin_rdata    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (dbg_win) begin
                    state_d     = ST_ISSUE;
                    owner_dbg_d = 1'b1;
                    s_req_d     = 1'b1;
                    s_we_d      = dbg_we;
                    s_addr_d    = dbg_addr;
                    s_wdata_d   = dbg_wdata;
                    if (!core_req) begin
                        dbg_cnt_d = '0;
                    end else if (dbg_cnt_q != CNT_MAX) begin
                        dbg_cnt_d = dbg_cnt_q + CNT_W'(1);
                    end
                end else if (core_req) begin
                    state_d     = ST_ISSUE;
                    owner_dbg_d = 1'b0;
                    s_req_d     = 1'b1;
                    s_we_d      = core_we;
                    s_addr_d    = core_addr;
                    s_wdata_d   = core_wdata;
                    dbg_cnt_d   = '0;
                end else begin
                    dbg_cnt_d = '0;
                end
            end
            ST_ISSUE: begin
                if (s_gnt) begin
                    state_d = ST_WAIT;
                    s_req_d = 1'b0;
                    tmo_d   = TMO_LOAD;
                end
            end
            ST_WAIT: begin
                if (s_rvalid || (tmo_q == '0)) begin
                    fin       = 1'b1;
                    fin_err   = ~s_rvalid;
                    fin_rdata = (s_rvalid && !s_we_q) ? s_rdata : '0;
                    state_d   = ST_IDLE;
                    s_we_d    = 1'b0;
                    s_addr_d  = '0;
                    s_wdata_d = '0;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_req_d = 1'b0;
            end
        endcase

        if (fin) begin
            if (owner_dbg_q) begin
                dbg_done_d  = 1'b1;
                dbg_err_d   = fin_err;
                dbg_rdata_d = fin_rdata;
            end else begin
                core_done_d  = 1'b1;
                core_err_d   = fin_err;
                core_rdata_d = fin_rdata;
            end
        end
    end

    // State and registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_dbg_q  <= 1'b0;
            dbg_cnt_q    <= '0;
            tmo_q        <= '0;
            s_req_q      <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            core_done_q  <= 1'b0;
            core_err_q   <= 1'b0;
            core_rdata_q <= '0;
            dbg_done_q   <= 1'b0;
            dbg_err_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_dbg_q  <= owner_dbg_d;
            dbg_cnt_q    <= dbg_cnt_d;
            tmo_q        <= tmo_d;
            s_req_q      <= s_req_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            core_done_q  <= core_done_d;
            core_err_q   <= core_err_d;
            core_rdata_q <= core_rdata_d;
            dbg_done_q   <= dbg_done_d;
            dbg_err_q    <= dbg_err_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign s_req      = s_req_q;
    assign s_we       = s_we_q;
    assign s_addr     = s_addr_q;
    assign s_wdata    = s_wdata_q;
    assign core_done  = core_done_q;
    assign core_err   = core_err_q;
    assign core_rdata = core_rdata_q;
    assign dbg_done   = dbg_done_q;
    assign dbg_err    = dbg_err_q;
    assign dbg_rdata  = dbg_rdata_q;

    // The pipeline stalls while debug is asking for or holding the bus.
    assign core_hold = dbg_req | (owner_dbg_q & (state_q != ST_IDLE));

endmodule
